// File: rtl/display_bcd_decoder_if.sv
// Result handshake between the display read-back decoder and its consumer.
// The decoder drives the result fields and valid; the consumer drives ready.
interface display_bcd_decoder_if;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_value;
    logic       out_dash;
    logic       out_err;

    modport master (output out_valid, output out_value, output out_dash, output out_err,
                    input  out_ready);
    modport slave  (input  out_valid, input  out_value, input  out_dash, input  out_err,
                    output out_ready);
endinterface

// File: rtl/display_bcd_decoder.sv
// Recovers a 0..15 value from a two-digit active-low seven-segment pattern,
// debounced by a stability window and delivered once per new stable pattern.
module display_bcd_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [13:0]            display_in,
    display_bcd_decoder_if.master  res,
    output logic [CNT_W-1:0]       err_count
);

    localparam int unsigned DISP_W = 14;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned VAL_W  = 4;
    localparam int unsigned STAB_W = 8;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_ONE   = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1111110;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {SAMPLE, OFFER} state_t;

    state_t              state, state_d;
    logic [DISP_W-1:0]   disp_q;
    logic [DISP_W-1:0]   last_q;
    logic [STAB_W-1:0]   stab_cnt;
    logic                delivered;
    logic                valid_q;
    logic [VAL_W-1:0]    value_q;
    logic                dash_q;
    logic                err_q;

    logic                stable_c;
    logic                load_c;
    logic                ack_c;
    logic [SEG_W-1:0]    tens_c;
    logic [SEG_W-1:0]    units_c;
    logic [VAL_W-1:0]    unit_idx_c;
    logic                unit_ok_c;
    logic [VAL_W-1:0]    dec_value_c;
    logic                dec_dash_c;
    logic                dec_err_c;

    // Stability is counted against the pattern being loaded, so the counter
    // already reads 0 on the cycle a new pattern first appears in disp_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q   <= '0;
            stab_cnt <= '0;
        end else begin
            disp_q <= display_in;
            if (display_in != disp_q)
                stab_cnt <= '0;
            else if (stab_cnt != STAB_W'(STABLE_CYCLES))
                stab_cnt <= stab_cnt + STAB_W'(1);
        end
    end

    assign stable_c = (stab_cnt == STAB_W'(STABLE_CYCLES));
    assign tens_c   = disp_q[13:7];
    assign units_c  = disp_q[6:0];

    // Units digit lookup
    always_comb begin
        unit_idx_c = '0;
        unit_ok_c  = 1'b1;
        case (units_c)
            7'b0000001: unit_idx_c = VAL_W'(0);
            7'b1001111: unit_idx_c = VAL_W'(1);
            7'b0010010: unit_idx_c = VAL_W'(2);
            7'b0000110: unit_idx_c = VAL_W'(3);
            7'b1001100: unit_idx_c = VAL_W'(4);
            7'b0100100: unit_idx_c = VAL_W'(5);
            7'b0100000: unit_idx_c = VAL_W'(6);
            7'b0001111: unit_idx_c = VAL_W'(7);
            7'b0000000: unit_idx_c = VAL_W'(8);
            7'b0001100: unit_idx_c = VAL_W'(9);
            default:    unit_ok_c  = 1'b0;
        endcase
    end

    // Whole-pattern classification: number, dash pair, or error
    always_comb begin
        dec_value_c = '0;
        dec_dash_c  = 1'b0;
        dec_err_c   = 1'b0;
        if (tens_c == SEG_BLANK && unit_ok_c)
            dec_value_c = unit_idx_c;
        else if (tens_c == SEG_ONE && unit_ok_c && unit_idx_c <= VAL_W'(5))
            dec_value_c = unit_idx_c + VAL_W'(10);
        else if (tens_c == SEG_DASH && units_c == SEG_DASH)
            dec_dash_c = 1'b1;
        else
            dec_err_c = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SAMPLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        load_c  = 1'b0;
        ack_c   = 1'b0;
        case (state)
            SAMPLE: begin
                if (stable_c && (!delivered || disp_q != last_q)) begin
                    state_d = OFFER;
                    load_c  = 1'b1;
                end
            end
            OFFER: begin
                if (valid_q && res.out_ready) begin
                    state_d = SAMPLE;
                    ack_c   = 1'b1;
                end
            end
            default: state_d = SAMPLE;
        endcase
    end

    // Result capture, delivery bookkeeping and error tally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            value_q   <= '0;
            dash_q    <= 1'b0;
            err_q     <= 1'b0;
            last_q    <= '0;
            delivered <= 1'b0;
            err_count <= '0;
        end else begin
            valid_q <= (state_d == OFFER);
            if (load_c) begin
                value_q <= dec_value_c;
                dash_q  <= dec_dash_c;
                err_q   <= dec_err_c;
                last_q  <= disp_q;
                if (dec_err_c && err_count != CNT_MAX)
                    err_count <= err_count + CNT_W'(1);
            end
            if (ack_c)
                delivered <= 1'b1;
        end
    end

    assign res.out_valid = valid_q;
    assign res.out_value = value_q;
    assign res.out_dash  = dash_q;
    assign res.out_err   = err_q;

endmodule

// File: tb/tb_display_bcd_decoder.sv
// Scoreboard bench for display_bcd_decoder: a reference classifier predicts
// each delivery; a negedge monitor pops and compares on every handshake.
module tb_display_bcd_decoder;

    localparam int unsigned STABLE = 4;
    localparam int unsigned CNTW   = 8;

    localparam logic [6:0] UNITS [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                          7'b0000000, 7'b0001100};

    typedef struct {
        logic [3:0]  v;
        logic        d;
        logic        e;
        int unsigned ec;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [13:0]     display_in = 14'h3FFF;
    logic [CNTW-1:0] err_count;

    display_bcd_decoder_if res ();

    display_bcd_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .display_in (display_in),
        .res        (res),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    exp_t        sb[$];
    bit          m_del = 1'b0;
    logic [13:0] m_last = '0;
    int unsigned m_ec = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [13:0] enc(input int unsigned v);
        if (v < 10) return {7'b1111111, UNITS[v]};
        return {7'b1001111, UNITS[v-10]};
    endfunction

    function automatic exp_t classify(input logic [13:0] p);
        exp_t        r;
        int          idx;
        logic [6:0]  t;
        logic [6:0]  u;
        t   = p[13:7];
        u   = p[6:0];
        idx = -1;
        for (int i = 0; i < 10; i++) if (UNITS[i] == u) idx = i;
        r.v = 4'd0; r.d = 1'b0; r.e = 1'b0; r.ec = 0;
        if (t == 7'b1111111 && idx >= 0)               r.v = 4'(idx);
        else if (t == 7'b1001111 && idx >= 0 && idx <= 5) r.v = 4'(idx + 10);
        else if (t == 7'b1111110 && u == 7'b1111110)    r.d = 1'b1;
        else                                            r.e = 1'b1;
        return r;
    endfunction

    task automatic expect_if_new(input logic [13:0] p);
        exp_t it;
        if (!m_del || p != m_last) begin
            it = classify(p);
            if (it.e && m_ec < 255) m_ec++;
            it.ec  = m_ec;
            sb.push_back(it);
            m_last = p;
            m_del  = 1'b1;
        end
    endtask

    task automatic apply(input logic [13:0] p, input int unsigned hold);
        @(posedge clk); #2;
        display_in = p;
        if (hold >= STABLE + 1) expect_if_new(p);
        repeat (hold - 1) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && res.out_valid && res.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_delivery", 1, 0);
            end else begin
                exp_t it;
                it = sb.pop_front();
                check("value", res.out_value, it.v);
                check("dash",  res.out_dash,  it.d);
                check("err",   res.out_err,   it.e);
                check("err_count", err_count, it.ec);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned lat;
        res.out_ready = 1'b1;
        display_in    = enc(3);
        #12;
        check("rst_valid", res.out_valid, 0);
        check("rst_value", res.out_value, 0);
        check("rst_dash",  res.out_dash,  0);
        check("rst_err",   res.out_err,   0);
        check("rst_err_count", err_count, 0);

        // First delivery latency from reset release
        @(posedge clk); #2;
        rst_n = 1'b1;
        expect_if_new(enc(3));
        lat = 99;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (res.out_valid) begin lat = k; break; end
        end
        check("latency", lat, STABLE + 1);
        repeat (10) @(posedge clk);

        for (int v = 0; v < 16; v++) apply(enc(v), 8);

        apply(14'b11111101111110, 8);
        apply(14'b10011110100000, 8);
        apply(14'b11111111111111, 8);
        @(posedge clk); #1;
        check("err_count_after_errs", err_count, m_ec);

        // Glitches must never be offered nor cause re-delivery
        apply(enc(7), 8);
        apply(enc(8), 1);
        apply(enc(7), 8);
        apply(enc(8), 3);
        apply(enc(7), 8);

        // Backpressure: held result survives a pattern change
        @(posedge clk); #2;
        res.out_ready = 1'b0;
        apply(enc(2), 8);
        @(posedge clk); #2;
        display_in = enc(9);
        expect_if_new(enc(9));
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("hold_valid", res.out_valid, 1);
            check("hold_value", res.out_value, 2);
        end
        @(posedge clk); #2;
        res.out_ready = 1'b1;
        @(posedge clk); #2;
        res.out_ready = 1'b0;
        check("after_ack_valid", res.out_valid, 0);
        @(posedge clk); #1;
        check("next_valid", res.out_valid, 1);
        check("next_value", res.out_value, 9);
        @(posedge clk); #2;
        res.out_ready = 1'b1;
        repeat (3) @(posedge clk);

        // Reset while a result is pending
        @(posedge clk); #2;
        res.out_ready = 1'b0;
        display_in = enc(5);
        repeat (10) @(posedge clk);
        #1;
        check("pending_valid", res.out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_valid", res.out_valid, 0);
        check("midreset_err_count", err_count, 0);
        m_ec  = 0;
        m_del = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        res.out_ready = 1'b1;
        expect_if_new(enc(5));
        lat = 99;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (res.out_valid) begin lat = k; break; end
        end
        check("relatency", lat, STABLE + 1);

        // Error counter saturation
        for (int i = 0; i < 300; i++)
            apply((i % 2 == 0) ? 14'b11111111111111 : 14'b10011110100000, 6);
        repeat (4) @(posedge clk);
        #1;
        check("err_count_sat", err_count, 255);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
